// File: rtl/vga_overlay_pipe.sv
// vga_overlay_pipe: HUD digit and sprite compositor sitting between the VGA
// scan counter and the pixel-index RAM / palette. Score and elapsed time are
// converted to decimal by a sequential engine and committed at frame start.
module vga_overlay_pipe #(
  parameter int SCORE_DIGITS = 4,
  parameter int SCORE_BITS   = 14,
  parameter int BLOCKS       = 4,
  parameter int CELL         = 20,
  parameter int GLYPH_W      = 21,
  parameter int GLYPH_H      = 25,
  parameter int GLYPH_BASE   = 307200,
  parameter int SCORE_X0     = 415,
  parameter int SCORE_Y0     = 300,
  parameter int TIME_X0      = 410,
  parameter int TIME_Y0      = 415,
  parameter int TIME_GAP     = 11
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [18:0]           curAddress,
  input  logic [9:0]            curX,
  input  logic [9:0]            curY,
  input  logic [31:0]           score,
  input  logic [15:0]           seconds,
  input  logic [7:0]            blockType,
  input  logic [10*BLOCKS-1:0]  bx,
  input  logic [10*BLOCKS-1:0]  by,
  input  logic [7:0]            indexIn,
  input  logic [23:0]           colorIn,
  output logic [18:0]           addrToRead,
  output logic [7:0]            indexOut,
  output logic [23:0]           colorOut,
  output logic                  out_valid,
  output logic                  busy
);

  // Decimal digits needed to hold 2^SCORE_BITS-1 (floor(n*log10(2))+1).
  localparam int BIN_DIGITS = (SCORE_BITS * 30103) / 100000 + 1;
  localparam int MAX_DIGITS = (BIN_DIGITS > SCORE_DIGITS) ? BIN_DIGITS : SCORE_DIGITS;
  localparam int GLYPH_SIZE = GLYPH_W * GLYPH_H;

  typedef enum logic [2:0] {IDLE, SCORE_BCD, DIV60, TIME_BCD, DONE} state_t;

  state_t state, next_state;
  logic [5:0]                 cnt;
  logic [31:0]                snap_score, last_score;
  logic [15:0]                snap_seconds, last_seconds;
  logic [SCORE_BITS-1:0]      bin_sh;
  logic [4*BIN_DIGITS-1:0]    score_bcd;
  logic [4*MAX_DIGITS-1:0]    score_wide;
  logic                       score_over;
  logic [15:0]                div_q, q_next;
  logic [5:0]                 div_r, r_next;
  logic [6:0]                 r_shift;
  logic [15:0]                min_sh, sec_sh;
  logic [7:0]                 min_bcd, sec_bcd;
  logic                       start;
  logic                       pending;
  logic [3:0]                 new_score [SCORE_DIGITS];
  logic [3:0]                 new_time [4];
  logic [3:0]                 shadow_score [SCORE_DIGITS];
  logic [3:0]                 shadow_time [4];
  logic [3:0]                 shown_score [SCORE_DIGITS];
  logic [3:0]                 shown_time [4];
  logic [18:0]                cur_x19, cur_y19, box_x, box_y, glyph_addr;
  logic [3:0]                 digit;
  logic                       in_box;
  logic                       hit, hit_d, valid_d1;

  // One shift-add-3 step over the wide score BCD register.
  function automatic logic [4*BIN_DIGITS-1:0] dd_score(input logic [4*BIN_DIGITS-1:0] bcd,
                                                       input logic bit_in);
    logic [4*BIN_DIGITS-1:0] adj;
    adj = bcd;
    for (int j = 0; j < BIN_DIGITS; j++)
      if (adj[4*j +: 4] >= 4'd5) adj[4*j +: 4] = adj[4*j +: 4] + 4'd3;
    return {adj[4*BIN_DIGITS-2:0], bit_in};
  endfunction

  // One shift-add-3 step over a two-digit BCD pair.
  function automatic logic [7:0] dd_pair(input logic [7:0] bcd, input logic bit_in);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], bit_in};
  endfunction

  // A cell hits when the pixel lies inside it; a cell whose far edge wraps 10 bits never hits.
  function automatic logic cell_hit(input logic [9:0] ox, input logic [9:0] oy,
                                    input logic [9:0] x, input logic [9:0] y);
    logic [10:0] ex, ey;
    ex = {1'b0, ox} + 11'(CELL);
    ey = {1'b0, oy} + 11'(CELL);
    return !ex[10] && !ey[10] && (x >= ox) && ({1'b0, x} < ex) && (y >= oy) && ({1'b0, y} < ey);
  endfunction

  assign start = (score != last_score) || (seconds != last_seconds);
  assign busy  = (state != IDLE);

  // Conversion engine state register.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= next_state;

  // Conversion engine sequencing: each phase runs a fixed number of single-step cycles.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = SCORE_BCD;
      SCORE_BCD: if (cnt == 6'(SCORE_BITS - 1)) next_state = DIV60;
      DIV60:     if (cnt == 6'd15) next_state = TIME_BCD;
      TIME_BCD:  if (cnt == 6'd15) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // One restoring-divide step of the seconds snapshot by 60.
  always_comb begin
    r_shift = {div_r, div_q[15]};
    q_next  = {div_q[14:0], (r_shift >= 7'd60)};
    r_next  = (r_shift >= 7'd60) ? 6'(r_shift - 7'd60) : r_shift[5:0];
  end

  // Conversion datapath: snapshot, score double-dabble, divide by 60, time double-dabble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      snap_score   <= '0;
      snap_seconds <= '0;
      last_score   <= '0;
      last_seconds <= '0;
      bin_sh       <= '0;
      score_bcd    <= '0;
      div_q        <= '0;
      div_r        <= '0;
      min_sh       <= '0;
      sec_sh       <= '0;
      min_bcd      <= '0;
      sec_bcd      <= '0;
    end else begin
      cnt <= (state == IDLE || next_state != state) ? 6'd0 : cnt + 6'd1;
      case (state)
        IDLE: if (start) begin
          snap_score   <= score;
          snap_seconds <= seconds;
          bin_sh       <= score[SCORE_BITS-1:0];
          score_bcd    <= '0;
        end
        SCORE_BCD: begin
          score_bcd <= dd_score(score_bcd, bin_sh[SCORE_BITS-1]);
          bin_sh    <= bin_sh << 1;
          div_q     <= snap_seconds;
          div_r     <= '0;
        end
        DIV60: begin
          div_q   <= q_next;
          div_r   <= r_next;
          min_sh  <= (q_next > 16'd99) ? 16'd99 : q_next;
          sec_sh  <= {10'd0, r_next};
          min_bcd <= '0;
          sec_bcd <= '0;
        end
        TIME_BCD: begin
          min_bcd <= dd_pair(min_bcd, min_sh[15]);
          sec_bcd <= dd_pair(sec_bcd, sec_sh[15]);
          min_sh  <= min_sh << 1;
          sec_sh  <= sec_sh << 1;
        end
        DONE: begin
          last_score   <= snap_score;
          last_seconds <= snap_seconds;
        end
        default: ;
      endcase
    end
  end

  // Finished digit values, with the score saturating to all nines when it needs more digits.
  always_comb begin
    score_wide = (4*MAX_DIGITS)'(score_bcd);
    score_over = 1'b0;
    for (int j = SCORE_DIGITS; j < MAX_DIGITS; j++)
      if (score_wide[4*j +: 4] != 4'd0) score_over = 1'b1;
    for (int k = 0; k < SCORE_DIGITS; k++)
      new_score[k] = score_over ? 4'd9 : score_wide[4*(SCORE_DIGITS-1-k) +: 4];
    new_time[0] = min_bcd[7:4];
    new_time[1] = min_bcd[3:0];
    new_time[2] = sec_bcd[7:4];
    new_time[3] = sec_bcd[3:0];
  end

  // Shadow digits take each finished conversion; displayed digits change only at frame start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      for (int k = 0; k < SCORE_DIGITS; k++) begin
        shadow_score[k] <= '0;
        shown_score[k]  <= '0;
      end
      for (int j = 0; j < 4; j++) begin
        shadow_time[j] <= '0;
        shown_time[j]  <= '0;
      end
    end else begin
      if (state == DONE) begin
        for (int k = 0; k < SCORE_DIGITS; k++) shadow_score[k] <= new_score[k];
        for (int j = 0; j < 4; j++) shadow_time[j] <= new_time[j];
      end
      if (frame_start && (pending || state == DONE)) begin
        pending <= 1'b0;
        for (int k = 0; k < SCORE_DIGITS; k++)
          shown_score[k] <= (state == DONE) ? new_score[k] : shadow_score[k];
        for (int j = 0; j < 4; j++)
          shown_time[j] <= (state == DONE) ? new_time[j] : shadow_time[j];
      end else if (state == DONE) begin
        pending <= 1'b1;
      end
    end
  end

  // Locate the glyph box under the pixel and form its glyph-strip address.
  always_comb begin
    cur_x19 = 19'(curX);
    cur_y19 = 19'(curY);
    in_box  = 1'b0;
    box_x   = '0;
    box_y   = '0;
    digit   = '0;
    if (cur_y19 >= 19'(SCORE_Y0) && cur_y19 < 19'(SCORE_Y0 + GLYPH_H))
      for (int k = 0; k < SCORE_DIGITS; k++)
        if (cur_x19 >= 19'(SCORE_X0 + k*GLYPH_W) && cur_x19 < 19'(SCORE_X0 + (k+1)*GLYPH_W)) begin
          in_box = 1'b1;
          box_x  = 19'(SCORE_X0 + k*GLYPH_W);
          box_y  = 19'(SCORE_Y0);
          digit  = shown_score[k];
        end
    if (cur_y19 >= 19'(TIME_Y0) && cur_y19 < 19'(TIME_Y0 + GLYPH_H))
      for (int j = 0; j < 4; j++)
        if (cur_x19 >= 19'(TIME_X0 + j*GLYPH_W + ((j >= 2) ? TIME_GAP : 0)) &&
            cur_x19 <  19'(TIME_X0 + (j+1)*GLYPH_W + ((j >= 2) ? TIME_GAP : 0))) begin
          in_box = 1'b1;
          box_x  = 19'(TIME_X0 + j*GLYPH_W + ((j >= 2) ? TIME_GAP : 0));
          box_y  = 19'(TIME_Y0);
          digit  = shown_time[j];
        end
    glyph_addr = 19'(GLYPH_BASE) + 19'(digit) * 19'(GLYPH_SIZE)
               + (cur_x19 - box_x) + (cur_y19 - box_y) * 19'(GLYPH_W);
  end

  // Any sprite cell covering the current pixel.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BLOCKS; i++)
      if (cell_hit(bx[10*i +: 10], by[10*i +: 10], curX, curY)) hit = 1'b1;
  end

  // Two-stage pixel pipeline: address and hit in stage 1, palette index in stage 2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addrToRead <= '0;
      hit_d      <= 1'b0;
      valid_d1   <= 1'b0;
      indexOut   <= '0;
      colorOut   <= '0;
      out_valid  <= 1'b0;
    end else begin
      addrToRead <= in_box ? glyph_addr : curAddress;
      hit_d      <= hit;
      valid_d1   <= pix_valid;
      indexOut   <= hit_d ? blockType : indexIn;
      out_valid  <= valid_d1;
      colorOut   <= colorIn;
    end
  end

endmodule

// File: tb/tb_vga_overlay_pipe.sv
// tb_vga_overlay_pipe: directed tables, multi-cycle sequences and randomized
// streaming checked against a decimal/arithmetic model of the overlay.
module tb_vga_overlay_pipe;

  localparam int GW = 21, GH = 25, GBASE = 307200;
  localparam int SX0 = 415, SY0 = 300, TX0 = 410, TY0 = 415, GAP = 11, CELLP = 20;

  logic        clock = 1'b0, resetn = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
  logic [18:0] curAddress = '0;
  logic [9:0]  curX = '0, curY = '0;
  logic [31:0] score = '0;
  logic [15:0] seconds = '0;
  logic [7:0]  blockType = '0, indexIn = '0;
  logic [39:0] bx = {4{10'd1010}}, by = {4{10'd1010}};
  logic [23:0] colorIn = '0;
  logic [18:0] addrToRead;
  logic [7:0]  indexOut;
  logic [23:0] colorOut;
  logic        out_valid, busy;

  int compared = 0, mismatched = 0;
  int exp_sd[4];
  int exp_tm[4];

  typedef struct { int x; int y; int addr; } vec_t;
  typedef struct { bit v; int addr; bit hit; int idx; int color; } pix_t;
  vec_t vecs[14];

  vga_overlay_pipe dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .pix_valid(pix_valid),
    .curAddress(curAddress), .curX(curX), .curY(curY), .score(score), .seconds(seconds),
    .blockType(blockType), .bx(bx), .by(by), .indexIn(indexIn), .colorIn(colorIn),
    .addrToRead(addrToRead), .indexOut(indexOut), .colorOut(colorOut),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit v);
    curX       = 10'(x);
    curY       = 10'(y);
    curAddress = 19'(y * 640 + x);
    pix_valid  = v;
  endtask

  // Expected displayed digits from the plain decimal meaning of score and seconds.
  task automatic set_model(input logic [31:0] sc, input logic [15:0] secs);
    int v, m, s;
    v = int'(sc[13:0]);
    if (v > 9999) v = 9999;
    exp_sd[0] = v / 1000;
    exp_sd[1] = (v / 100) % 10;
    exp_sd[2] = (v / 10) % 10;
    exp_sd[3] = v % 10;
    m = int'(secs) / 60;
    s = int'(secs) % 60;
    if (m > 99) m = 99;
    exp_tm[0] = m / 10;
    exp_tm[1] = m % 10;
    exp_tm[2] = s / 10;
    exp_tm[3] = s % 10;
  endtask

  function automatic int model_addr(input int x, input int y);
    int left;
    if (y >= SY0 && y < SY0 + GH)
      for (int k = 0; k < 4; k++) begin
        left = SX0 + k * GW;
        if (x >= left && x < left + GW)
          return GBASE + exp_sd[k] * GW * GH + (x - left) + (y - SY0) * GW;
      end
    if (y >= TY0 && y < TY0 + GH)
      for (int j = 0; j < 4; j++) begin
        left = TX0 + j * GW + ((j >= 2) ? GAP : 0);
        if (x >= left && x < left + GW)
          return GBASE + exp_tm[j] * GW * GH + (x - left) + (y - TY0) * GW;
      end
    return (y * 640 + x) % 524288;
  endfunction

  function automatic bit model_hit(input int x, input int y);
    int ox, oy;
    for (int i = 0; i < 4; i++) begin
      ox = int'(bx[10*i +: 10]);
      oy = int'(by[10*i +: 10]);
      if (ox + CELLP < 1024 && oy + CELLP < 1024 &&
          x >= ox && x < ox + CELLP && y >= oy && y < oy + CELLP) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clock);
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, int'(busy), 0);
  endtask

  task automatic pulse_frame();
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic probe_addr(input string name, input int x, input int y, input int expected);
    @(negedge clock);
    applyStimulus(x, y, 1'b1);
    @(negedge clock);
    pix_valid = 1'b0;
    checkOutput(name, int'(addrToRead), expected);
  endtask

  task automatic probe_index(input string name, input int x, input int y, input int expected);
    @(negedge clock);
    applyStimulus(x, y, 1'b1);
    @(negedge clock);
    pix_valid = 1'b0;
    @(negedge clock);
    checkOutput(name, int'(indexOut), expected);
    checkOutput({name, "_valid"}, int'(out_valid), 1);
  endtask

  task automatic stream_round(input int cycles);
    pix_t cur, last, last2;
    last  = '{0, 0, 0, 0, 0};
    last2 = '{0, 0, 0, 0, 0};
    repeat (2) @(negedge clock) pix_valid = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      if (n > 0) begin
        if (last.v) checkOutput("stream_addr", int'(addrToRead), last.addr);
        checkOutput("stream_valid", int'(out_valid), int'(last2.v));
        if (last2.v)
          checkOutput("stream_index", int'(indexOut), last2.hit ? int'(blockType) : last.idx);
        checkOutput("stream_color", int'(colorOut), last.color);
      end
      cur.v     = ($urandom_range(0, 3) != 0);
      cur.idx   = int'($urandom_range(0, 255));
      cur.color = int'($urandom_range(0, 24'hFFFFFF));
      begin
        int x, y;
        x = int'($urandom_range(370, 530));
        y = int'($urandom_range(285, 450));
        applyStimulus(x, y, cur.v);
        cur.addr = model_addr(x, y);
        cur.hit  = model_hit(x, y);
      end
      indexIn = 8'(cur.idx);
      colorIn = 24'(cur.color);
      last2 = last;
      last  = cur;
    end
    @(negedge clock);
    pix_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{484, 415, 309300};
    vecs[1]  = '{455, 415, 266055};
    vecs[2]  = '{410, 415, 307725};
    vecs[3]  = '{431, 439, 308754};
    vecs[4]  = '{463, 420, 308880};
    vecs[5]  = '{504, 439, 309824};
    vecs[6]  = '{505, 415, 266105};
    vecs[7]  = '{414, 300, 192414};
    vecs[8]  = '{415, 325, 208415};
    vecs[9]  = '{498, 324, 309824};
    vecs[10] = '{452, 415, 266052};
    vecs[11] = '{436, 310, 308460};
    vecs[12] = '{462, 439, 281422};
    vecs[13] = '{451, 415, 308270};

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("rst_addr", int'(addrToRead), 0);
    checkOutput("rst_index", int'(indexOut), 0);
    checkOutput("rst_color", int'(colorOut), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    resetn = 1'b1;

    // Reset in the middle of a score conversion abandons it.
    @(negedge clock);
    score = 32'd1234;
    repeat (3) @(negedge clock);
    checkOutput("busy_converting", int'(busy), 1);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("busy_in_reset", int'(busy), 0);
    @(negedge clock);
    resetn = 1'b1;
    probe_addr("rst_abandon_digit", 415, 300, 307200);

    // Finished conversion stays hidden until frame start.
    wait_idle("idle_1234");
    probe_addr("hold_until_frame", 415, 300, 307200);
    pulse_frame();
    set_model(32'd1234, 16'd0);
    probe_addr("score_d0", 416, 301, 307747);
    probe_addr("score_d3", 478, 300, 309300);
    probe_addr("time_zero", 410, 415, model_addr(410, 415));

    // Time field layout with 12:34.
    seconds = 16'd754;
    wait_idle("idle_754");
    pulse_frame();
    set_model(32'd1234, 16'd754);
    for (int i = 0; i < 14; i++)
      probe_addr($sformatf("table_%0d", i), vecs[i].x, vecs[i].y, vecs[i].addr);

    // Saturation of score and minutes.
    score   = 32'd12000;
    seconds = 16'd65535;
    wait_idle("idle_sat");
    pulse_frame();
    set_model(32'd12000, 16'd65535);
    probe_addr("score_sat", 478, 300, 311925);
    probe_addr("min1_sat", 410, 415, 311925);
    probe_addr("min0_sat", 431, 415, 311925);
    probe_addr("sec1_15", 463, 415, 307725);
    probe_addr("sec0_15", 484, 415, 309825);

    // Mid-frame completion keeps old digits until the next frame start.
    score = 32'd42;
    wait_idle("idle_42");
    probe_addr("old_digits_kept", 478, 300, 311925);
    pulse_frame();
    set_model(32'd42, 16'd65535);
    probe_addr("new_d3", 478, 300, 308250);
    probe_addr("new_d2", 457, 300, 309300);
    probe_addr("new_d0", 415, 300, 307200);

    // Sprite cell edges and the overflowing-origin case.
    blockType = 8'h05;
    indexIn   = 8'h11;
    bx[9:0]   = 10'd100;
    by[9:0]   = 10'd200;
    probe_index("sprite_in", 119, 219, 8'h05);
    probe_index("sprite_right", 120, 219, 8'h11);
    probe_index("sprite_origin", 100, 200, 8'h05);
    probe_index("sprite_left", 99, 200, 8'h11);
    probe_index("sprite_below", 119, 220, 8'h11);
    probe_index("sprite_wrap", 1015, 1015, 8'h11);

    // Randomized values, sprites and back-to-back pixels against the model.
    for (int r = 0; r < 4; r++) begin
      score   = (r == 0) ? $urandom() : 32'($urandom_range(0, 20000));
      seconds = 16'($urandom());
      blockType = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
        bx[10*i +: 10] = (i == 3) ? 10'($urandom_range(1005, 1023)) : 10'($urandom_range(380, 520));
        by[10*i +: 10] = (i == 3) ? 10'($urandom_range(290, 450))   : 10'($urandom_range(290, 450));
      end
      wait_idle("idle_random");
      pulse_frame();
      set_model(score, seconds);
      stream_round(250);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
